// File: rtl/vs_pkg.sv
// vs_pkg: shared FSM encoding, constants and width helpers for the top-K vector search engine
`ifndef VS_PKG_SV
`define VS_PKG_SV
`define VS_SCORE_FITS(EW, L, Q, SW) ((2 * (EW) + 1 + vs_pkg::vs_clog2((L) * (Q))) <= (SW))
package vs_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} vs_state_e;
    localparam int DRAIN_CYCLES = 3;
    function automatic int vs_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage
`endif

// File: rtl/vs_topk_insert.sv
// vs_topk_insert: K-entry descending (score,id) list with single-cycle sorted insert and flush
module vs_topk_insert import vs_pkg::*; #(
    parameter int K       = 4,
    parameter int SCORE_W = 32,
    parameter int ID_W    = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        ins_i,
    input  logic signed [SCORE_W-1:0]   score_i,
    input  logic [ID_W-1:0]             id_i,
    input  logic [vs_clog2(K)-1:0]      idx_i,
    output logic signed [SCORE_W-1:0]   score_o,
    output logic [ID_W-1:0]             id_o,
    output logic [vs_clog2(K+1)-1:0]    count_o
);
    localparam int CW = vs_clog2(K + 1);
    logic [K-1:0] v_q, v_d, above, prev;
    logic signed [SCORE_W-1:0] s_q [K];
    logic signed [SCORE_W-1:0] s_d [K];
    logic [ID_W-1:0] i_q [K];
    logic [ID_W-1:0] i_d [K];
    // Valid entries are contiguous and sorted, so "above" is monotone and its first set bit is the slot
    always_comb begin
        v_d = v_q;
        s_d = s_q;
        i_d = i_q;
        above = '0;
        for (int k = 0; k < K; k++)
            above[k] = !v_q[k] || (s_q[k] < score_i);
        prev = above << 1;
        for (int k = 0; k < K; k++) begin
            if (ins_i && above[k] && !prev[k]) begin
                v_d[k] = 1'b1;
                s_d[k] = score_i;
                i_d[k] = id_i;
            end else if (ins_i && prev[k]) begin
                v_d[k] = v_q[(k > 0) ? k - 1 : 0];
                s_d[k] = s_q[(k > 0) ? k - 1 : 0];
                i_d[k] = i_q[(k > 0) ? k - 1 : 0];
            end
        end
        if (flush_i) v_d = '0;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= '0;
            for (int k = 0; k < K; k++) begin
                s_q[k] <= '0;
                i_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            s_q <= s_d;
            i_q <= i_d;
        end
    end
    always_comb begin
        count_o = '0;
        for (int k = 0; k < K; k++)
            count_o = count_o + CW'(v_q[k]);
    end
    assign score_o = s_q[idx_i];
    assign id_o    = i_q[idx_i];
endmodule

// File: rtl/vs_topk_engine.sv
// vs_topk_engine: streams stored vectors from SRAM, dot-products them against a buffered query
// and keeps the K best (score,id) pairs.
module vs_topk_engine import vs_pkg::*; #(
    parameter int LANES   = 4,
    parameter int ELEM_W  = 8,
    parameter int ADDR_W  = 12,
    parameter int QDEPTH  = 64,
    parameter int K       = 4,
    parameter int ID_W    = 10,
    parameter int SCORE_W = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          q_wr_en_i,
    input  logic [vs_clog2(QDEPTH)-1:0]   q_wr_addr_i,
    input  logic [LANES*ELEM_W-1:0]       q_wr_data_i,
    input  logic                          start_i,
    input  logic                          signed_mode_i,
    input  logic [ADDR_W-1:0]             base_addr_i,
    input  logic [ID_W-1:0]               vector_count_i,
    input  logic [vs_clog2(QDEPTH):0]     dim_words_i,
    output logic                          mem_rd_en_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    input  logic [LANES*ELEM_W-1:0]       mem_rdata_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic [vs_clog2(K+1)-1:0]      res_count_o,
    input  logic [vs_clog2(K)-1:0]        res_idx_i,
    output logic signed [SCORE_W-1:0]     res_score_o,
    output logic [ID_W-1:0]               res_id_o
);
    localparam int WORD_W = LANES * ELEM_W;
    localparam int QA_W   = vs_clog2(QDEPTH);
    localparam int DW_W   = QA_W + 1;
    if (!(`VS_SCORE_FITS(ELEM_W, LANES, QDEPTH, SCORE_W))) begin : g_score_w_chk
        $error("SCORE_W too narrow for worst-case dot product");
    end
    vs_state_e state_q, state_d;
    logic start_acc, bad_dim, w_last, id_last, rd;
    logic sgn_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DW_W-1:0] dim_q, w_q;
    logic [ID_W-1:0] vc_q, id_q;
    logic [1:0] dcnt_q;
    logic p0_vld_q, p0_first_q, p0_last_q;
    logic [ID_W-1:0] p0_id_q;
    logic [QA_W-1:0] p0_w_q;
    logic p1_vld_q, p1_first_q, p1_last_q;
    logic [ID_W-1:0] p1_id_q;
    logic signed [SCORE_W-1:0] lsum_q, lsum_d, acc_q;
    logic ins_q;
    logic [ID_W-1:0] p2_id_q;
    logic [WORD_W-1:0] qmem_q [QDEPTH];
    logic [WORD_W-1:0] qword;
    logic signed [ELEM_W:0] a, b;
    logic signed [2*ELEM_W+1:0] p;
    assign bad_dim = (dim_words_i == '0) || (dim_words_i > DW_W'(QDEPTH));
    assign w_last  = w_q == dim_q - DW_W'(1);
    assign id_last = id_q == vc_q - ID_W'(1);
    assign rd      = state_q == S_SCAN;
    always_comb begin
        state_d = state_q;
        start_acc = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                start_acc = 1'b1;
                state_d = (bad_dim || vector_count_i == '0) ? S_DONE : S_SCAN;
            end
            S_SCAN:  state_d = (w_last && id_last) ? S_DRAIN : S_SCAN;
            S_DRAIN: state_d = (dcnt_q == 2'(DRAIN_CYCLES - 1)) ? S_DONE : S_DRAIN;
            default: state_d = S_IDLE;
        endcase
        if (clear_i) begin
            state_d = S_IDLE;
            start_acc = 1'b0;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else state_q <= state_d;
    end
    // Query buffer is write-only while idle so a running search sees a frozen query
    always_ff @(posedge clk_i) begin
        if (q_wr_en_i && state_q == S_IDLE) qmem_q[q_wr_addr_i] <= q_wr_data_i;
    end
    assign qword = qmem_q[p0_w_q];
    always_comb begin
        lsum_d = '0;
        a = '0;
        b = '0;
        p = '0;
        for (int l = 0; l < LANES; l++) begin
            a = {sgn_q & mem_rdata_i[l*ELEM_W+ELEM_W-1], mem_rdata_i[l*ELEM_W +: ELEM_W]};
            b = {sgn_q & qword[l*ELEM_W+ELEM_W-1], qword[l*ELEM_W +: ELEM_W]};
            p = a * b;
            lsum_d = lsum_d + SCORE_W'(p);
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sgn_q <= 1'b0;
            err_q <= 1'b0;
            addr_q <= '0;
            dim_q <= '0;
            w_q <= '0;
            vc_q <= '0;
            id_q <= '0;
            dcnt_q <= '0;
            p0_vld_q <= 1'b0;
            p0_first_q <= 1'b0;
            p0_last_q <= 1'b0;
            p0_id_q <= '0;
            p0_w_q <= '0;
            p1_vld_q <= 1'b0;
            p1_first_q <= 1'b0;
            p1_last_q <= 1'b0;
            p1_id_q <= '0;
            lsum_q <= '0;
            acc_q <= '0;
            ins_q <= 1'b0;
            p2_id_q <= '0;
        end else begin
            p0_vld_q <= rd && !clear_i;
            p0_first_q <= w_q == '0;
            p0_last_q <= w_last;
            p0_id_q <= id_q;
            p0_w_q <= w_q[QA_W-1:0];
            p1_vld_q <= p0_vld_q && !clear_i;
            p1_first_q <= p0_first_q;
            p1_last_q <= p0_last_q;
            p1_id_q <= p0_id_q;
            lsum_q <= lsum_d;
            ins_q <= p1_vld_q && p1_last_q && !clear_i;
            p2_id_q <= p1_id_q;
            if (p1_vld_q) acc_q <= p1_first_q ? lsum_q : acc_q + lsum_q;
            dcnt_q <= (state_q == S_DRAIN) ? dcnt_q + 2'd1 : 2'd0;
            if (start_acc) begin
                sgn_q <= signed_mode_i;
                err_q <= bad_dim;
                addr_q <= base_addr_i;
                dim_q <= dim_words_i;
                vc_q <= vector_count_i;
                w_q <= '0;
                id_q <= '0;
            end else if (rd) begin
                addr_q <= addr_q + ADDR_W'(1);
                w_q <= w_last ? '0 : w_q + DW_W'(1);
                id_q <= w_last ? id_q + ID_W'(1) : id_q;
            end
        end
    end
    vs_topk_insert #(.K(K), .SCORE_W(SCORE_W), .ID_W(ID_W)) u_list (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clear_i || start_acc),
        .ins_i   (ins_q),
        .score_i (acc_q),
        .id_i    (p2_id_q),
        .idx_i   (res_idx_i),
        .score_o (res_score_o),
        .id_o    (res_id_o),
        .count_o (res_count_o)
    );
    assign mem_rd_en_o = rd;
    assign mem_addr_o  = addr_q;
    assign busy_o      = state_q != S_IDLE;
    assign done_o      = state_q == S_DONE;
    assign err_o       = err_q;
endmodule
